mem_dump_ctrl: RTL and testbench
================================

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

Interface
REQ-001 SHALL have parameter INST_SZ, default 32, data memory word width in bits (multiple of 8).
REQ-002 SHALL have parameter MEM_SZ, default 5, data memory address width (2^MEM_SZ words).
REQ-003 SHALL have port i_clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  one-cycle request to dump the whole data memory.
REQ-006 SHALL have port i_abort  input  1  synchronous cancel of a dump in progress.
REQ-007 SHALL have port i_debug_mem  input  INST_SZ  word read from data memory at o_debug_addr, valid one cycle after the address changes.
REQ-008 SHALL have port i_tx_done  input  1  one-cycle pulse from the UART transmitter when the current byte has been sent.
REQ-009 SHALL have port o_debug_addr  output  MEM_SZ  data memory debug read address.
REQ-010 SHALL have port o_tx_data  output  8  byte to transmit.
REQ-011 SHALL have port o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-012 SHALL have port o_busy  output  1  high from the cycle after an accepted i_start until return to IDLE.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse after the last byte of the last word has been sent.

Function
REQ-014 SHALL implement FSM states IDLE, SET_ADDR, LOAD, SEND, WAIT_TX, NEXT, DONE.
REQ-015 IDLE: i_start=1 and i_abort=0 -> SET_ADDR with address counter 0 and byte counter 0; otherwise stay.
REQ-016 SET_ADDR: drive o_debug_addr from address counter for one cycle, then -> LOAD.
REQ-017 LOAD: capture i_debug_mem into a word shift register, then -> SEND.
REQ-018 SEND: o_tx_start=1 for exactly this cycle with o_tx_data = word register bits [7:0] (LSB byte first), then -> WAIT_TX.
REQ-019 WAIT_TX: hold o_tx_data stable; on i_tx_done=1 -> NEXT; no timeout.
REQ-020 NEXT: if byte counter < INST_SZ/8-1: shift word register right 8, increment byte counter, -> SEND; else if address counter < 2^MEM_SZ-1: increment address, clear byte counter, -> SET_ADDR; else -> DONE.
REQ-021 DONE: o_done=1 for one cycle, address and byte counters cleared to 0, -> IDLE.
REQ-022 Defaults: one dump = 2^MEM_SZ words x INST_SZ/8 bytes (32 x 4 = 128 bytes), words in ascending address order.
REQ-023 i_start while not IDLE SHALL be ignored.
REQ-024 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-025 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge, counters cleared, no o_done, no further o_tx_start; i_abort=1 together with i_start in IDLE keeps IDLE.
REQ-026 i_tx_done arriving in the same cycle as i_abort: abort wins.
REQ-027 Address counter SHALL not wrap mid-dump; the last address is 2^MEM_SZ-1.
REQ-028 o_debug_addr SHALL equal the address counter in all states (0 in IDLE).
REQ-029 All outputs SHALL be registered or decoded from the state register only; no combinational path from inputs to outputs.

Reset
REQ-030 i_reset=0 SHALL asynchronously force IDLE, address counter 0, byte counter 0, word register 0.
REQ-031 During and after reset until i_start: o_debug_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0.
REQ-032 Reset mid-dump SHALL abandon the dump without o_done; the next i_start restarts from address 0.

Structure
REQ-033 FSM state encoding and the bytes-per-word constant SHALL live in the shared debug-unit package.
REQ-034 The block SHALL be a single module with no sub-modules; the UART transmitter and data memory stay outside and connect via o_tx_*/i_tx_done and o_debug_addr/i_debug_mem.

Verification
REQ-035 Memory word k = 0x0000_0100+k, i_tx_done 3 cycles after each o_tx_start, pulse i_start -> 128 o_tx_start pulses, bytes 00,01,00,00,01,01,00,00,... ending 1F,01,00,00, then exactly one o_done, o_busy falls with return to IDLE.
REQ-036 i_abort after the 10th byte -> no further o_tx_start, no o_done, o_busy=0 next cycle, o_debug_addr=0; a new i_start restarts at address 0 byte 00.
REQ-037 i_start pulsed again at byte 50 and spurious i_tx_done during SEND and LOAD -> byte stream identical to REQ-035.
REQ-038 i_reset low at word 7 byte 2 -> all outputs 0 immediately (asynchronous); after release and i_start, dump starts at address 0.
REQ-039 i_tx_done withheld 1000 cycles in WAIT_TX -> o_tx_data stable, no extra o_tx_start, dump resumes on i_tx_done.

Source files
------------

// File: rtl/mem_dump_ctrl_pkg.sv
// Shared debug-unit definitions: dump FSM
// state encoding and word/byte geometry.
package mem_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_ADDR,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT,
    ST_DONE
  } dump_state_e;

  localparam int unsigned INST_SZ_DEF = 32;
  localparam int unsigned MEM_SZ_DEF  = 5;

  // Bytes carried by one data memory word.
  function automatic int unsigned bytes_per_word(
    input int unsigned inst_sz
  );
    return inst_sz / 8;
  endfunction

  localparam int unsigned BYTES_PER_WORD_DEF =
    bytes_per_word(INST_SZ_DEF);

endpackage

// File: rtl/mem_dump_ctrl.sv
// Streams the whole data memory out over the
// UART, LSB byte first, words in address order.
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int unsigned INST_SZ = INST_SZ_DEF,
  parameter int unsigned MEM_SZ  = MEM_SZ_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [INST_SZ-1:0] i_debug_mem,
  input  logic               i_tx_done,
  output logic [MEM_SZ-1:0]  o_debug_addr,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned NBYTES =
    bytes_per_word(INST_SZ);
  localparam int unsigned BW =
    (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE =
    BW'(NBYTES - 1);
  localparam logic [MEM_SZ-1:0] LAST_ADDR = '1;

  dump_state_e        state_q;
  logic [MEM_SZ-1:0]  addr_q;
  logic [BW-1:0]      byte_q;
  logic [INST_SZ-1:0] word_q;

  // Dump sequencer: abort overrides every
  // non-idle state, including a tx_done pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else if (i_abort && state_q != ST_IDLE) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            state_q <= ST_SET_ADDR;
            addr_q  <= '0;
            byte_q  <= '0;
          end
        end
        ST_SET_ADDR: state_q <= ST_LOAD;
        ST_LOAD: begin
          word_q  <= i_debug_mem;
          state_q <= ST_SEND;
        end
        ST_SEND: state_q <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (i_tx_done) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (byte_q != LAST_BYTE) begin
            word_q  <= word_q >> 8;
            byte_q  <= byte_q + BW'(1);
            state_q <= ST_SEND;
          end else if (addr_q != LAST_ADDR) begin
            addr_q  <= addr_q + MEM_SZ'(1);
            byte_q  <= '0;
            state_q <= ST_SET_ADDR;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          addr_q  <= '0;
          byte_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_debug_addr = addr_q;
  assign o_tx_data    = word_q[7:0];
  assign o_tx_start   = (state_q == ST_SEND);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Scoreboard bench for mem_dump_ctrl: expected
// bytes queued by stimulus, popped by monitor.
module tb_mem_dump_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       resp_done = 1'b0;
  logic       spur_done = 1'b0;
  logic       i_tx_done;
  logic [31:0] mem_q = '0;
  logic [4:0] dbg_addr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int resp_n = 0;
  int hold_at = -1;
  logic [7:0] exp_q[$];

  assign i_tx_done = resp_done | spur_done;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk)
    mem_q <= 32'h100 + 32'(dbg_addr);

  mem_dump_ctrl #(.INST_SZ(32), .MEM_SZ(5)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_debug_mem(mem_q),
    .i_tx_done(i_tx_done),
    .o_debug_addr(dbg_addr),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy),
    .o_done(done)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push_bytes(input int nbytes);
    logic [31:0] w;
    for (int i = 0; i < nbytes; i++) begin
      w = 32'h100 + 32'(i / 4);
      exp_q.push_back(8'(w >> (8 * (i % 4))));
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm,
                           input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge i_clk);
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_bytes(input string nm,
                            input int nb);
    int n;
    n = 0;
    for (int i = 0; i < 2000 && n < nb; i++) begin
      @(negedge i_clk);
      if (tx_start) n++;
    end
    chk({nm, "_bytes_reached"}, 32'(n), 32'(nb));
  endtask

  task automatic post_dump(input string nm,
                           input int d0,
                           input int t0);
    @(negedge i_clk);
    chk({nm, "_busy_low"}, 32'(busy), 32'd0);
    chk({nm, "_addr_zero"}, 32'(dbg_addr), 32'd0);
    repeat (5) @(negedge i_clk);
    chk({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_tx_count"}, 32'(tx_cnt - t0), 32'd128);
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare each sent byte, and hold
  // of tx_data between start pulses.
  initial begin
    logic [7:0] last;
    logic [7:0] e;
    last = '0;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        last = '0;
      end else if (tx_start) begin
        tx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_start: got %0h expected none",
                   tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e));
        end
        last = tx_data;
      end else if (busy) begin
        chk("tx_data_hold", 32'(tx_data), 32'(last));
      end
      if (done) done_cnt++;
    end
  end

  // UART model: tx_done 3 cycles after each
  // start, or 1000 for the selected byte.
  initial begin
    int d;
    forever begin
      @(negedge i_clk);
      if (tx_start) begin
        resp_n++;
        d = (resp_n == hold_at) ? 1000 : 3;
        repeat (d) @(negedge i_clk);
        resp_done = 1'b1;
        @(negedge i_clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    int d0;
    int t0;
    int n;
    logic a20;
    logic load_nxt;
    logic seen;

    repeat (3) @(negedge i_clk);
    chk("rst_addr", 32'(dbg_addr), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    @(negedge i_clk);

    d0 = done_cnt;
    t0 = tx_cnt;
    push_bytes(128);
    pulse_start();
    chk("d1_busy_high", 32'(busy), 32'd1);
    chk("d1_addr0", 32'(dbg_addr), 32'd0);
    wait_done("d1", 3000);
    post_dump("d1", d0, t0);

    d0 = done_cnt;
    t0 = tx_cnt;
    push_bytes(128);
    pulse_start();
    n = 0;
    a20 = 1'b0;
    load_nxt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      spur_done = 1'b0;
      if (done) seen = 1'b1;
      if (tx_start) begin
        n++;
        if (n == 50) i_start = 1'b1;
        if (n == 60) spur_done = 1'b1;
      end
      if (load_nxt) begin
        spur_done = 1'b1;
        load_nxt = 1'b0;
      end else if (dbg_addr == 5'd20 && !a20) begin
        a20 = 1'b1;
        load_nxt = 1'b1;
      end
    end
    chk("d2_done_seen", 32'(seen), 32'd1);
    post_dump("d2", d0, t0);

    d0 = done_cnt;
    t0 = tx_cnt;
    push_bytes(10);
    pulse_start();
    wait_bytes("ab", 10);
    repeat (3) @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("ab_busy_low", 32'(busy), 32'd0);
    chk("ab_addr_zero", 32'(dbg_addr), 32'd0);
    repeat (20) @(negedge i_clk);
    chk("ab_tx_count", 32'(tx_cnt - t0), 32'd10);
    chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ab_queue_empty", 32'(exp_q.size()), 32'd0);

    d0 = done_cnt;
    t0 = tx_cnt;
    push_bytes(128);
    hold_at = resp_n + 30;
    pulse_start();
    chk("d3_addr0", 32'(dbg_addr), 32'd0);
    wait_done("d3", 4000);
    post_dump("d3", d0, t0);
    hold_at = -1;

    t0 = tx_cnt;
    push_bytes(31);
    pulse_start();
    wait_bytes("rs", 31);
    #2 i_reset = 1'b0;
    #1;
    chk("rs_addr", 32'(dbg_addr), 32'd0);
    chk("rs_data", 32'(tx_data), 32'd0);
    chk("rs_start", 32'(tx_start), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("rs_idle_busy", 32'(busy), 32'd0);

    d0 = done_cnt;
    t0 = tx_cnt;
    push_bytes(128);
    pulse_start();
    chk("d4_busy_high", 32'(busy), 32'd1);
    chk("d4_addr0", 32'(dbg_addr), 32'd0);
    wait_done("d4", 3000);
    post_dump("d4", d0, t0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
